// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the 19-bit processor datapath. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and the sequencer strobes the
// PC, IR, register file, flag registers and data memory in the proper cycle.
// Instruction and data memory accesses stall on their ready handshakes. A
// stall lasting TIMEOUT cycles parks the machine in HALT with bus_error set
// until the next reset.
//
// Parameters:
//   TIMEOUT  consecutive stalled cycles in FETCH or MEM before HALT (1..255)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   instr           current IR contents (decoded in EXEC/MEM/WB)
//   zero_flag       registered Z flag (sampled in EXEC for BZ)
//   carry_flag      registered C flag (sampled in EXEC for BC)
//   imem_ready      instruction memory data valid this cycle
//   dmem_ready      data memory access completes this cycle
//   imemRead        instruction fetch request
//   irWrite         load IR
//   enablePC        PC <= PC + 1
//   pcLoad          PC <= branch/jump target
//   enableZero      load Z flag
//   enableCarry     load C flag
//   memRead         data memory read (LDM)
//   memWrite        data memory write (STM)
//   regWrite        register file write
//   selectToWrite   write-back source: 00 ALU, 01 memory, 10 shifter
//   bus_error       sticky timeout indication
//   retired         retired-instruction count (wraps)
//   state           current state encoding
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [18:0]      instr,
    input  logic             zero_flag,
    input  logic             carry_flag,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imemRead,
    output logic             irWrite,
    output logic             enablePC,
    output logic             pcLoad,
    output logic             enableZero,
    output logic             enableCarry,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic [1:0]       selectToWrite,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Last stall count that may still be survived; a further not-ready cycle
    // at this count ends in HALT.
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         stall_q, stall_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;

    // ---------------------------------------------------------------------
    // Instruction decode (instr holds the IR loaded at the end of FETCH)
    // ---------------------------------------------------------------------
    logic       is_alu;
    logic       is_mem;
    logic       is_stm;
    logic       is_ctl;
    logic       is_shift;
    logic [1:0] ctl_op;
    logic       branch_taken;
    logic [1:0] wb_sel;

    assign is_alu   = ~instr[18];
    assign is_mem   = (instr[18:17] == 2'b10);
    assign is_stm   = instr[16];
    assign is_ctl   = (instr[18:17] == 2'b11);
    assign ctl_op   = instr[16:15];
    assign is_shift = is_ctl && (ctl_op == 2'b00);

    // JMP always loads; BZ/BC load only when their flag is set.
    assign branch_taken = is_ctl && ((ctl_op == 2'b01) ||
                                     ((ctl_op == 2'b10) && zero_flag) ||
                                     ((ctl_op == 2'b11) && carry_flag));

    // Only ALU, shift and LDM reach WB, so the memory class means LDM here.
    assign wb_sel = is_mem   ? 2'b01 :
                    is_shift ? 2'b10 : 2'b00;

    // Operand fields are the datapath's business, not the sequencer's.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[14:0];

    // ---------------------------------------------------------------------
    // Next-state, stall counter and retire logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        retire  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (stall_q == STALL_LIMIT) begin
                    state_d = S_HALT;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu || is_shift) begin
                    state_d = S_WB;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_stm) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (stall_q == STALL_LIMIT) begin
                    state_d = S_HALT;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Every state entry starts a fresh stall window.
        if (state_d != state_q) begin
            stall_d = 8'd0;
        end

        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            stall_q   <= 8'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            retired_q <= retired_d;
        end
    end

    // ---------------------------------------------------------------------
    // Output decode. Strobes follow the registered state; irWrite/enablePC
    // additionally wait for imem_ready and pcLoad for the branch condition.
    // Reset suppresses every strobe even before the state register clears.
    // ---------------------------------------------------------------------
    always_comb begin
        imemRead      = 1'b0;
        irWrite       = 1'b0;
        enablePC      = 1'b0;
        pcLoad        = 1'b0;
        enableZero    = 1'b0;
        enableCarry   = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        regWrite      = 1'b0;
        selectToWrite = 2'b00;

        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    imemRead = 1'b1;
                    irWrite  = imem_ready;
                    enablePC = imem_ready;
                end
                S_EXEC: begin
                    enableZero  = is_alu || is_shift;
                    enableCarry = is_alu || is_shift;
                    pcLoad      = branch_taken;
                end
                S_MEM: begin
                    memRead  = ~is_stm;
                    memWrite = is_stm;
                end
                S_WB: begin
                    regWrite      = 1'b1;
                    selectToWrite = wb_sel;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_error = (state_q == S_HALT);
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Builds, per instruction, the expected cycle-by-cycle output trace from the
// instruction class and the number of wait cycles chosen for each memory,
// then replays that trace against the DUT one cycle at a time. Directed
// scenarios come first (with literal expectations read straight off the DUT),
// followed by randomized instructions, wait patterns and reset aborts.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int TMO = 15;
    localparam int CW  = 4;
    localparam int OW  = CW + 15;

    // strobe field bit positions: imemRead..regWrite
    localparam logic [8:0] S_IMR = 9'h100;
    localparam logic [8:0] S_IRW = 9'h080;
    localparam logic [8:0] S_EPC = 9'h040;
    localparam logic [8:0] S_PCL = 9'h020;
    localparam logic [8:0] S_EZ  = 9'h010;
    localparam logic [8:0] S_EC  = 9'h008;
    localparam logic [8:0] S_MR  = 9'h004;
    localparam logic [8:0] S_MW  = 9'h002;
    localparam logic [8:0] S_RW  = 9'h001;

    localparam logic [OW-1:0] FULL      = '1;
    localparam logic [OW-1:0] M_STROBES = {3'b000, 9'h1FF, 2'b00, 1'b0, {CW{1'b0}}};
    localparam logic [OW-1:0] M_RST     = {3'b111, 9'h1FF, 2'b00, 1'b0, {CW{1'b1}}};

    typedef struct packed {
        logic          rst;
        logic [18:0]   ins;
        logic          zf;
        logic          cf;
        logic          ir;
        logic          dr;
        logic [OW-1:0] exp;
        logic [OW-1:0] msk;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [18:0]   instr;
    logic          zero_flag, carry_flag, imem_ready, dmem_ready;
    logic          imemRead, irWrite, enablePC, pcLoad, enableZero, enableCarry;
    logic          memRead, memWrite, regWrite, bus_error;
    logic [1:0]    selectToWrite;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    multicycle_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imemRead(imemRead), .irWrite(irWrite), .enablePC(enablePC),
        .pcLoad(pcLoad), .enableZero(enableZero), .enableCarry(enableCarry),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .selectToWrite(selectToWrite), .bus_error(bus_error),
        .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    cyc_t          plan[$];
    logic [CW-1:0] ret_m;
    bit            halted;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            obs[9];
    string         tag;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [18:0] rnd19();
        return 19'($urandom);
    endfunction

    function automatic logic [OW-1:0] mk(input int st, input logic [8:0] sb,
                                         input logic [1:0] sel, input logic be,
                                         input logic [CW-1:0] r);
        return {3'(st), sb, sel, be, r};
    endfunction

    function automatic logic [OW-1:0] ex(input int st, input logic [8:0] sb,
                                         input logic [1:0] sel, input logic be);
        return mk(st, sb, sel, be, ret_m);
    endfunction

    task automatic push(input logic r, input logic [18:0] i, input logic z, input logic c,
                        input logic ir, input logic dr, input logic [OW-1:0] e,
                        input logic [OW-1:0] m);
        cyc_t t;
        t.rst = r; t.ins = i; t.zf = z; t.cf = c; t.ir = ir; t.dr = dr;
        t.exp = e; t.msk = m;
        plan.push_back(t);
    endtask

    task automatic gen_halt();
        for (int k = 0; k < 3; k++)
            push(1'b0, rnd19(), rb(), rb(), rb(), rb(), ex(5, 9'h000, 2'b00, 1'b1), FULL);
        halted = 1'b1;
    endtask

    // Expected trace of one instruction with wi fetch waits and wd data waits.
    task automatic gen_instr(input logic [18:0] ins, input logic zf, input logic cf,
                             input int wi, input int wd);
        logic       is_mem, is_ctl, is_stm, tk;
        logic [1:0] op;
        logic [8:0] ms;
        int         nst;
        is_mem = (ins[18:17] == 2'b10);
        is_ctl = (ins[18:17] == 2'b11);
        is_stm = ins[16];
        op     = ins[16:15];

        nst = (wi < TMO) ? wi : TMO;
        for (int k = 0; k < nst; k++)
            push(1'b0, rnd19(), rb(), rb(), 1'b0, rb(), ex(0, S_IMR, 2'b00, 1'b0), FULL);
        if (wi >= TMO) begin
            gen_halt();
            return;
        end
        push(1'b0, rnd19(), rb(), rb(), 1'b1, rb(), ex(0, S_IMR | S_IRW | S_EPC, 2'b00, 1'b0), FULL);
        push(1'b0, ins, rb(), rb(), rb(), rb(), ex(1, 9'h000, 2'b00, 1'b0), FULL);

        if (is_ctl && op != 2'b00) begin
            tk = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? zf : cf;
            push(1'b0, ins, zf, cf, rb(), rb(), ex(2, tk ? S_PCL : 9'h000, 2'b00, 1'b0), FULL);
            ret_m = ret_m + 1'b1;
        end else if (!is_mem) begin
            push(1'b0, ins, zf, cf, rb(), rb(), ex(2, S_EZ | S_EC, 2'b00, 1'b0), FULL);
            push(1'b0, ins, rb(), rb(), rb(), rb(), ex(4, S_RW, is_ctl ? 2'b10 : 2'b00, 1'b0), FULL);
            ret_m = ret_m + 1'b1;
        end else begin
            push(1'b0, ins, zf, cf, rb(), rb(), ex(2, 9'h000, 2'b00, 1'b0), FULL);
            ms  = is_stm ? S_MW : S_MR;
            nst = (wd < TMO) ? wd : TMO;
            for (int k = 0; k < nst; k++)
                push(1'b0, ins, rb(), rb(), rb(), 1'b0, ex(3, ms, 2'b00, 1'b0), FULL);
            if (wd >= TMO) begin
                gen_halt();
                return;
            end
            push(1'b0, ins, rb(), rb(), rb(), 1'b1, ex(3, ms, 2'b00, 1'b0), FULL);
            if (is_stm) begin
                ret_m = ret_m + 1'b1;
            end else begin
                push(1'b0, ins, rb(), rb(), rb(), rb(), ex(4, S_RW, 2'b01, 1'b0), FULL);
                ret_m = ret_m + 1'b1;
            end
        end
    endtask

    // Reset for n cycles; the first cycle still shows the pre-reset state.
    task automatic gen_reset(input int st, input logic [CW-1:0] r, input int n);
        push(1'b1, rnd19(), rb(), rb(), rb(), rb(), mk(st, 9'h000, 2'b00, 1'b0, r), M_RST);
        for (int k = 1; k < n; k++)
            push(1'b1, rnd19(), rb(), rb(), rb(), rb(), mk(0, 9'h000, 2'b00, 1'b0, '0), M_RST);
        ret_m  = '0;
        halted = 1'b0;
    endtask

    // Drop the plan from index p onward and assert reset in that cycle instead.
    task automatic cut_with_reset(input int p);
        int            st;
        logic [CW-1:0] r;
        st = int'(plan[p].exp[OW-1 -: 3]);
        r  = plan[p].exp[CW-1:0];
        while (plan.size() > p) void'(plan.pop_back());
        gen_reset(st, r, 1);
    endtask

    task automatic step(input cyc_t c);
        logic [OW-1:0] act;
        rst = c.rst; instr = c.ins; zero_flag = c.zf; carry_flag = c.cf;
        imem_ready = c.ir; dmem_ready = c.dr;
        #3;
        act = {state, imemRead, irWrite, enablePC, pcLoad, enableZero, enableCarry,
               memRead, memWrite, regWrite, selectToWrite, bus_error, retired};
        checks++;
        if ((act & c.msk) !== (c.exp & c.msk)) begin
            failures++;
            $display("FAIL %s cycle %0d: dut=%h model=%h (state|strobes|sel|berr|retired)",
                     tag, cyc, act & c.msk, c.exp & c.msk);
        end
        for (int j = 0; j < 9; j++)
            if (act[CW + 3 + j] === 1'b1) obs[j]++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            step(c);
        end
    endtask

    task automatic clear_obs();
        for (int j = 0; j < 9; j++) obs[j] = 0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 0;
        if (r < 8) return int'($urandom_range(1, 3));
        return int'($urandom_range(TMO - 3, TMO + 1));
    endfunction

    initial begin
        rst = 1'b1; instr = '0; zero_flag = 1'b0; carry_flag = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        ret_m = '0; halted = 1'b0;
        @(posedge clk);
        #1;

        tag = "reset";
        push(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 9'h000, 2'b00, 1'b0, '0), M_STROBES);
        push(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 9'h000, 2'b00, 1'b0, '0), M_RST);
        run_plan();
        chk("reset_state", int'(state), 0);
        chk("reset_retired", int'(retired), 0);
        chk("reset_bus_error", int'(bus_error), 0);

        tag = "alu_reg";
        clear_obs();
        gen_instr({2'b00, 17'($urandom)}, rb(), rb(), 0, 0);
        run_plan();
        chk("alu_flag_strobes", obs[4], 1);
        chk("alu_regwrite", obs[0], 1);
        chk("alu_retired", int'(retired), 1);

        tag = "ldm_wait3";
        clear_obs();
        gen_instr({3'b100, 16'($urandom)}, rb(), rb(), 0, 3);
        run_plan();
        chk("ldm_memread_cycles", obs[2], 4);
        chk("ldm_retired", int'(retired), 2);

        tag = "bz_not_taken";
        clear_obs();
        gen_instr({4'b1110, 15'($urandom)}, 1'b0, rb(), 0, 0);
        run_plan();
        chk("bz0_pcload", obs[5], 0);
        tag = "bz_taken";
        clear_obs();
        gen_instr({4'b1110, 15'($urandom)}, 1'b1, rb(), 0, 0);
        run_plan();
        chk("bz1_pcload", obs[5], 1);
        chk("bz_retired", int'(retired), 4);

        tag = "fetch_timeout";
        clear_obs();
        gen_instr({2'b00, 17'($urandom)}, rb(), rb(), TMO, 0);
        run_plan();
        chk("timeout_state", int'(state), 5);
        chk("timeout_bus_error", int'(bus_error), 1);
        chk("timeout_imemread_cycles", obs[8], 15);
        tag = "halt_reset";
        gen_reset(5, ret_m, 1);
        run_plan();
        chk("halt_reset_bus_error", int'(bus_error), 0);
        chk("halt_reset_state", int'(state), 0);

        tag = "fetch_ready_at_limit";
        clear_obs();
        gen_instr({2'b01, 17'($urandom)}, rb(), rb(), TMO - 1, 0);
        run_plan();
        chk("limit_bus_error", int'(bus_error), 0);
        chk("limit_imemread_cycles", obs[8], 15);
        chk("limit_retired", int'(retired), 1);

        tag = "stm_abort";
        gen_reset(0, ret_m, 1);
        run_plan();
        clear_obs();
        gen_instr({3'b101, 16'($urandom)}, rb(), rb(), 0, 5);
        cut_with_reset(4);
        run_plan();
        chk("abort_memwrite_cycles", obs[1], 1);
        chk("abort_state", int'(state), 0);
        chk("abort_retired", int'(retired), 0);
        chk("abort_bus_error", int'(bus_error), 0);

        tag = "jmp_wrap";
        gen_reset(0, ret_m, 1);
        for (int n = 0; n < 17; n++)
            gen_instr({4'b1101, 15'($urandom)}, rb(), rb(), 0, 0);
        run_plan();
        chk("wrap_retired", int'(retired), 1);

        tag = "random";
        for (int n = 0; n < 300; n++) begin
            gen_instr(rnd19(), rb(), rb(), pick_wait(), pick_wait());
            if (halted)
                gen_reset(5, ret_m, int'($urandom_range(1, 2)));
            else if ($urandom_range(0, 15) == 0)
                cut_with_reset(int'($urandom_range(0, plan.size() - 1)));
            run_plan();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
